// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer.
// State enum, mode codes, level limit, score width.
package game_pkg;

  typedef enum logic [1:0] {
    ST_HOME,
    ST_PLAY,
    ST_END
  } state_t;

  localparam logic [3:0] MODE_HOME      = 4'd0;
  localparam logic [3:0] MODE_END       = 4'd1;
  localparam logic [3:0] MODE_PLAY_BASE = 4'd2;
  localparam logic [1:0] LEVEL_MAX      = 2'd2;
  localparam int         SCORE_W        = 11;

  function automatic logic [3:0] mode_of(
    input state_t     s,
    input logic [1:0] lvl
  );
    logic [3:0] m;
    m = MODE_HOME;
    unique case (s)
      ST_HOME: m = MODE_HOME;
      ST_PLAY: m = MODE_PLAY_BASE + {2'b00, lvl};
      ST_END:  m = MODE_END;
      default: m = MODE_HOME;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop sync, stable-count filter, press pulse.
// Ports: CLK, RST (sync, high), raw in; level (filtered), press (1-cycle on rise).
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Any cycle agreeing with the accepted level restarts the count,
  // so only an unbroken run of DEB_CYCLES differing cycles is accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= s2;
          press <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: HOME -> PLAY -> END, level select, score keeping.
// Ports: CLK, RST, btn_*, over, score in; mode, level, game_rst, scores out.
module game_ctrl
  import game_pkg::*;
#(
  parameter int DEB_CYCLES      = 1_000_000,
  parameter int END_HOLD_CYCLES = 200_000_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               btn_start,
  input  logic               btn_select,
  input  logic               btn_back,
  input  logic               over,
  input  logic [SCORE_W-1:0] score,
  output logic [3:0]         mode,
  output logic [1:0]         level,
  output logic               game_rst,
  output logic [SCORE_W-1:0] last_score,
  output logic [SCORE_W-1:0] best_score,
  output logic               new_record
);

  localparam int HW = $clog2(END_HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(END_HOLD_CYCLES - 1);

  logic [2:0] btn_lvl;
  logic       start_p;
  logic       select_p;
  logic       back_p;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
    .CLK   (CLK),
    .RST   (RST),
    .raw   (btn_start),
    .level (btn_lvl[0]),
    .press (start_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_select (
    .CLK   (CLK),
    .RST   (RST),
    .raw   (btn_select),
    .level (btn_lvl[1]),
    .press (select_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_back (
    .CLK   (CLK),
    .RST   (RST),
    .raw   (btn_back),
    .level (btn_lvl[2]),
    .press (back_p)
  );

  state_t             state_q;
  state_t             state_d;
  logic [1:0]         level_d;
  logic               grst_d;
  logic [SCORE_W-1:0] last_d;
  logic [SCORE_W-1:0] best_d;
  logic               rec_d;
  logic [HW-1:0]      hold_q;
  logic [HW-1:0]      hold_d;
  logic               hold_done;

  assign hold_done = (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    level_d = level;
    grst_d  = 1'b0;
    last_d  = last_score;
    best_d  = best_score;
    rec_d   = new_record;
    hold_d  = '0;
    unique case (state_q)
      ST_HOME: begin
        if (start_p) begin
          state_d = ST_PLAY;
          grst_d  = 1'b1;
        end else if (select_p) begin
          level_d = (level == LEVEL_MAX) ? 2'd0 : level + 2'd1;
        end
      end
      ST_PLAY: begin
        if (over) begin
          state_d = ST_END;
          last_d  = score;
          if (score > best_score) begin
            best_d = score;
            rec_d  = 1'b1;
          end else begin
            rec_d = 1'b0;
          end
        end else if (back_p) begin
          state_d = ST_HOME;
        end
      end
      ST_END: begin
        hold_d = hold_done ? hold_q : hold_q + 1'b1;
        // Early presses fall through here and are simply lost.
        if (hold_done && (start_p || back_p)) begin
          state_d = ST_HOME;
          rec_d   = 1'b0;
          hold_d  = '0;
        end
      end
      default: state_d = ST_HOME;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_HOME;
      mode       <= MODE_HOME;
      level      <= 2'd0;
      game_rst   <= 1'b0;
      last_score <= '0;
      best_score <= '0;
      new_record <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode       <= mode_of(state_d, level_d);
      level      <= level_d;
      game_rst   <= grst_d;
      last_score <= last_d;
      best_score <= best_d;
      new_record <= rec_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with short debounce and END hold.
// Drives and samples on the falling clock edge.
module tb_game_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_select = 1'b0;
  logic        btn_back = 1'b0;
  logic        over = 1'b0;
  logic [10:0] score = 11'd0;
  logic [3:0]  mode;
  logic [1:0]  level;
  logic        game_rst;
  logic [10:0] last_score;
  logic [10:0] best_score;
  logic        new_record;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  game_ctrl #(
    .DEB_CYCLES      (4),
    .END_HOLD_CYCLES (16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .btn_start  (btn_start),
    .btn_select (btn_select),
    .btn_back   (btn_back),
    .over       (over),
    .score      (score),
    .mode       (mode),
    .level      (level),
    .game_rst   (game_rst),
    .last_score (last_score),
    .best_score (best_score),
    .new_record (new_record)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // which: 0 start, 1 select, 2 back
  task automatic press(input int which, input int hold);
    case (which)
      0: btn_start = 1'b1;
      1: btn_select = 1'b1;
      default: btn_back = 1'b1;
    endcase
    tick(hold);
    btn_start  = 1'b0;
    btn_select = 1'b0;
    btn_back   = 1'b0;
    tick(8);
  endtask

  task automatic game_over(input logic [10:0] s);
    score = s;
    over  = 1'b1;
    tick(1);
    over = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(1);
    checks++;
    if (mode !== 4'd0 || level !== 2'd0 || game_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl mode=%0d level=%0d grst=%b want 0 0 0",
               mode, level, game_rst);
    end
    checks++;
    if (best_score !== 11'd0 || last_score !== 11'd0 || new_record !== 1'b0) begin
      errors++;
      $display("FAIL reset_score best=%0d last=%0d rec=%b want 0 0 0",
               best_score, last_score, new_record);
    end
  endtask

  task automatic test_select;
    logic [1:0] exp_lv [3];
    exp_lv[0] = 2'd1;
    exp_lv[1] = 2'd2;
    exp_lv[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      press(1, 6);
      checks++;
      if (level !== exp_lv[i] || mode !== 4'd0) begin
        errors++;
        $display("FAIL select%0d level=%0d mode=%0d want %0d 0",
                 i, level, mode, exp_lv[i]);
      end
    end
  endtask

  task automatic test_glitch;
    press(0, 1);
    checks++;
    if (mode !== 4'd0) begin
      errors++;
      $display("FAIL glitch1 mode=%0d want 0", mode);
    end
    press(0, 3);
    checks++;
    if (mode !== 4'd0) begin
      errors++;
      $display("FAIL glitch3 mode=%0d want 0", mode);
    end
  endtask

  task automatic test_start;
    int         grst_n;
    int         entries;
    logic [3:0] prev;
    press(1, 6);
    grst_n  = 0;
    entries = 0;
    prev    = mode;
    btn_start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i == 10) btn_start = 1'b0;
      tick(1);
      if (game_rst === 1'b1) grst_n++;
      if (prev == 4'd0 && mode == 4'd3) entries++;
      prev = mode;
    end
    checks++;
    if (grst_n !== 1 || entries !== 1) begin
      errors++;
      $display("FAIL start_hold grst_cycles=%0d entries=%0d want 1 1",
               grst_n, entries);
    end
    checks++;
    if (mode !== 4'd3 || level !== 2'd1) begin
      errors++;
      $display("FAIL play_mode mode=%0d level=%0d want 3 1", mode, level);
    end
  endtask

  task automatic leave_end;
    tick(16);
    press(0, 6);
  endtask

  task automatic test_scores;
    game_over(11'd300);
    checks++;
    if (mode !== 4'd1 || last_score !== 11'd300 ||
        best_score !== 11'd300 || new_record !== 1'b1) begin
      errors++;
      $display("FAIL game1 mode=%0d last=%0d best=%0d rec=%b want 1 300 300 1",
               mode, last_score, best_score, new_record);
    end
    leave_end;
    checks++;
    if (mode !== 4'd0 || new_record !== 1'b0) begin
      errors++;
      $display("FAIL end_exit mode=%0d rec=%b want 0 0", mode, new_record);
    end
    press(0, 6);
    game_over(11'd300);
    checks++;
    if (mode !== 4'd1 || best_score !== 11'd300 || new_record !== 1'b0) begin
      errors++;
      $display("FAIL game2_equal mode=%0d best=%0d rec=%b want 1 300 0",
               mode, best_score, new_record);
    end
    leave_end;
    press(0, 6);
    game_over(11'd12);
    checks++;
    if (last_score !== 11'd12 || best_score !== 11'd300 || new_record !== 1'b0) begin
      errors++;
      $display("FAIL game3_low last=%0d best=%0d rec=%b want 12 300 0",
               last_score, best_score, new_record);
    end
  endtask

  task automatic test_end_hold;
    press(0, 6);
    checks++;
    if (mode !== 4'd1) begin
      errors++;
      $display("FAIL end_early mode=%0d want 1", mode);
    end
    tick(6);
    checks++;
    if (mode !== 4'd1) begin
      errors++;
      $display("FAIL end_noqueue mode=%0d want 1", mode);
    end
    press(0, 6);
    checks++;
    if (mode !== 4'd0) begin
      errors++;
      $display("FAIL end_late mode=%0d want 0", mode);
    end
  endtask

  task automatic test_over_back;
    press(0, 6);
    btn_back = 1'b1;
    tick(6);
    score = 11'd77;
    over  = 1'b1;
    tick(1);
    over     = 1'b0;
    btn_back = 1'b0;
    checks++;
    if (mode !== 4'd1 || last_score !== 11'd77 || best_score !== 11'd300) begin
      errors++;
      $display("FAIL over_back mode=%0d last=%0d best=%0d want 1 77 300",
               mode, last_score, best_score);
    end
    leave_end;
    press(0, 6);
    score = 11'd55;
    press(2, 6);
    checks++;
    if (mode !== 4'd0 || last_score !== 11'd77) begin
      errors++;
      $display("FAIL back_only mode=%0d last=%0d want 0 77", mode, last_score);
    end
  endtask

  task automatic test_rst_mid_play;
    int moved;
    press(0, 6);
    btn_start = 1'b1;
    tick(4);
    RST       = 1'b1;
    btn_start = 1'b0;
    tick(1);
    checks++;
    if (mode !== 4'd0 || level !== 2'd0 || last_score !== 11'd0 ||
        best_score !== 11'd0 || new_record !== 1'b0) begin
      errors++;
      $display("FAIL rst_play mode=%0d lvl=%0d last=%0d best=%0d rec=%b want 0s",
               mode, level, last_score, best_score, new_record);
    end
    RST   = 1'b0;
    moved = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (mode !== 4'd0) moved++;
    end
    checks++;
    if (moved !== 0) begin
      errors++;
      $display("FAIL rst_no_press cycles_out_of_home=%0d want 0", moved);
    end
  endtask

  initial begin
    test_reset;
    test_select;
    test_glitch;
    test_start;
    test_scores;
    test_end_hold;
    test_over_back;
    test_rst_mid_play;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
